// File: rtl/ntt_pkg.sv
// Shared constants, FSM states and payload types for the ML-KEM NTT sequencer.
package ntt_pkg;

  localparam int unsigned N          = 256;
  localparam int unsigned LOG_N      = 8;
  localparam int unsigned NUM_LAYERS = 7;
  localparam int unsigned Q          = 3329;

  localparam int unsigned ADDR_W  = LOG_N;
  localparam int unsigned BF_W    = LOG_N - 1;
  localparam int unsigned TW_W    = 7;
  localparam int unsigned LAYER_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    MODE_NTT  = 1'b0,
    MODE_INTT = 1'b1
  } mode_e;

  // One butterfly's coefficient address pair plus its strobe.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
  } bf_req_t;

endpackage

// File: rtl/ntt_ctrl_if.sv
// Memory-side bus of the NTT sequencer: coefficient RAM reads/writes, twiddle index, BU strobe.
interface ntt_ctrl_if;
  import ntt_pkg::*;

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [TW_W-1:0]   tw_idx;
  logic              bu_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [ADDR_W-1:0] wr_addr_b;

  modport master (
    output rd_en, rd_addr_a, rd_addr_b, tw_idx, bu_valid,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    input rd_en, rd_addr_a, rd_addr_b, tw_idx, bu_valid,
    input wr_en, wr_addr_a, wr_addr_b
  );

endinterface

// File: rtl/ntt_addr_gen.sv
// Combinational map from (butterfly index, log2 len, mode) to RAM addresses and twiddle index.
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic [BF_W-1:0]    bf,
  input  logic [LAYER_W-1:0] lg,
  input  mode_e              mode,
  output logic [ADDR_W-1:0]  addr_a_c,
  output logic [ADDR_W-1:0]  addr_b_c,
  output logic [TW_W-1:0]    tw_idx_c
);

  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] grp;
  logic [ADDR_W-1:0] base;

  always_comb begin
    len      = ADDR_W'(1) << lg;
    grp      = ADDR_W'(bf) >> lg;
    // lg+1 can reach 8, so widen before shifting the group base
    base     = grp << (4'(lg) + 4'd1);
    addr_a_c = base | (ADDR_W'(bf) & (len - 1'b1));
    addr_b_c = addr_a_c + len;
    if (mode == MODE_NTT) begin
      tw_idx_c = TW_W'(((ADDR_W + 1)'(N / 2) >> lg) + (ADDR_W + 1)'(grp));
    end else begin
      tw_idx_c = TW_W'(((ADDR_W + 1)'(N) >> lg) - (ADDR_W + 1)'(1) - (ADDR_W + 1)'(grp));
    end
  end

endmodule

// File: rtl/ntt_ctrl.sv
// Sequences 7 NTT/INTT layers of butterflies over a 256-coefficient RAM, in-place write-back.
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned BU_LAT  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic       busy,
  output logic       done,
  ntt_ctrl_if.master mem
);

  localparam int unsigned PIPE  = MEM_LAT + BU_LAT;
  localparam int unsigned CNT_W = $clog2(PIPE + 1);

  state_e               state_q, state_d;
  mode_e                mode_q, mode_d;
  logic [BF_W-1:0]      bf_q, bf_d;
  logic [LAYER_W-1:0]   layer_q, layer_d;
  logic [CNT_W-1:0]     drain_q, drain_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  bf_req_t              rd_q, rd_d;
  logic [TW_W-1:0]      tw_q, tw_d;
  bf_req_t [PIPE-1:0]   pipe_q, pipe_d;

  logic [LAYER_W-1:0]   lg_d;
  logic [ADDR_W-1:0]    ag_addr_a;
  logic [ADDR_W-1:0]    ag_addr_b;
  logic [TW_W-1:0]      ag_tw;

  // Next-state and counters; lg_d is log2(len) of the butterfly issued next cycle
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    bf_d    = bf_q;
    layer_d = layer_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          mode_d  = mode_e'(mode);
          bf_d    = '0;
          layer_d = '0;
        end
      end
      RUN: begin
        bf_d = bf_q + 1'b1;
        if (bf_q == BF_W'(N / 2 - 1)) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 1'b1;
        // hold reads off until the layer's last write has landed
        if (drain_q == CNT_W'(PIPE - 1)) begin
          if (layer_q == LAYER_W'(NUM_LAYERS - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            bf_d    = '0;
            layer_d = layer_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    lg_d = (mode_d == MODE_NTT) ? (LAYER_W'(NUM_LAYERS) - layer_d) : (layer_d + 1'b1);
  end

  ntt_addr_gen u_addr_gen (
    .bf       (bf_d),
    .lg       (lg_d),
    .mode     (mode_d),
    .addr_a_c (ag_addr_a),
    .addr_b_c (ag_addr_b),
    .tw_idx_c (ag_tw)
  );

  // Registered read-side outputs; addresses are zeroed on idle cycles
  always_comb begin
    busy_d      = (state_d == RUN) || (state_d == DRAIN);
    done_d      = (state_d == DONE);
    rd_d.en     = (state_d == RUN);
    rd_d.addr_a = rd_d.en ? ag_addr_a : '0;
    rd_d.addr_b = rd_d.en ? ag_addr_b : '0;
    tw_d        = rd_d.en ? ag_tw : '0;
    pipe_d      = {pipe_q[PIPE-2:0], rd_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_NTT;
      bf_q    <= '0;
      layer_q <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      tw_q    <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      bf_q    <= bf_d;
      layer_q <= layer_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      tw_q    <= tw_d;
      pipe_q  <= pipe_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mem.rd_en     = rd_q.en;
  assign mem.rd_addr_a = rd_q.addr_a;
  assign mem.rd_addr_b = rd_q.addr_b;
  assign mem.tw_idx    = tw_q;
  assign mem.bu_valid  = pipe_q[MEM_LAT-1].en;
  assign mem.wr_en     = pipe_q[PIPE-1].en;
  assign mem.wr_addr_a = pipe_q[PIPE-1].addr_a;
  assign mem.wr_addr_b = pipe_q[PIPE-1].addr_b;

endmodule
